// File: rtl/data_mem_arb_pkg.sv
// Shared definitions for the two-port data memory arbiter: FSM encoding,
// default bus widths and requester port indices.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;

  localparam int P_CPU = 0;
  localparam int P_DBG = 1;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The arbiter takes the slave view; the environment (requesters + memory) takes master.
interface data_mem_arbiter_if
  import data_mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_write_en;
  logic              mem_read_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output mem_write_en, mem_read_en, mem_addr, mem_wdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  mem_write_en, mem_read_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, with a priority
// pointer that moves to the losing port whenever a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Port 0 winning hands priority to port 1 and vice versa.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates a CPU port and a debug/DMA port onto one combinational-read
// data memory: IDLE latches the winner, ACCESS strobes memory, RESP acks.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic               clk,
  input logic               rst_n,
  data_mem_arbiter_if.slave bus
);

  state_t            state;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic [1:0]        ack;
  logic              advance;
  logic              win_idx;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic              req_idx;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] data_reg;

  assign req     = {bus.p1_req, bus.p0_req};
  assign advance = (state == IDLE) && (grant != 2'b00);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

  assign win_idx   = grant[P_DBG];
  assign win_we    = win_idx ? bus.p1_we    : bus.p0_we;
  assign win_addr  = win_idx ? bus.p1_addr  : bus.p0_addr;
  assign win_wdata = win_idx ? bus.p1_wdata : bus.p0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_idx   <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      data_reg  <= '0;
      ack       <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          ack <= 2'b00;
          if (advance) begin
            req_idx   <= win_idx;
            req_we    <= win_we;
            req_addr  <= win_addr;
            req_wdata <= win_wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!req_we) begin
            data_reg <= bus.mem_rdata;
          end
          ack   <= req_idx ? 2'b10 : 2'b01;
          state <= RESP;
        end
        RESP: begin
          ack   <= 2'b00;
          state <= IDLE;
        end
        default: begin
          ack   <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from state so an asynchronous reset kills them at once.
  assign bus.mem_write_en = (state == ACCESS) &&  req_we;
  assign bus.mem_read_en  = (state == ACCESS) && !req_we;
  assign bus.mem_addr     = (state == ACCESS) ? req_addr  : '0;
  assign bus.mem_wdata    = (state == ACCESS) ? req_wdata : '0;

  assign bus.p0_ack   = ack[P_CPU];
  assign bus.p1_ack   = ack[P_DBG];
  assign bus.p0_rdata = (ack[P_CPU] && !req_we) ? data_reg : '0;
  assign bus.p1_rdata = (ack[P_DBG] && !req_we) ? data_reg : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, round-robin/starvation/reset
// sequences, and randomized traffic against a transaction-level reference model.
module tb_data_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   mem_init = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model state
  int          ptr_m = 0;
  logic [15:0] ref_mem [0:255];

  // results of the last serviced transaction
  int          last_win;
  int          last_ack_cyc;
  int          access_wait;
  logic [15:0] got_rdata;

  data_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural memory, 256 words, upper address bits wrap
  logic [15:0] tb_mem [0:255];
  assign bus.mem_rdata = tb_mem[bus.mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= 16'h0;
    end else if (bus.mem_write_en) begin
      tb_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic r, input logic we,
                       input logic [15:0] a, input logic [15:0] d);
    if (p == 0) begin
      bus.p0_req = r; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
    end else begin
      bus.p1_req = r; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
    end
  endtask

  // Wait for the next access, check strobes, ack, rdata against the model.
  task automatic serve(input bit keep, input bit scramble);
    logic [1:0]  pend;
    int          win;
    logic        we;
    logic [15:0] a, d, exp_rd;
    bit          seen;
    pend = {bus.p1_req, bus.p0_req};
    win  = (pend == 2'b11) ? ptr_m : (pend[1] ? 1 : 0);
    we   = (win == 1) ? bus.p1_we    : bus.p0_we;
    a    = (win == 1) ? bus.p1_addr  : bus.p0_addr;
    d    = (win == 1) ? bus.p1_wdata : bus.p0_wdata;
    exp_rd = we ? 16'h0 : ref_mem[a[7:0]];
    seen = 1'b0;
    access_wait = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.mem_write_en || bus.mem_read_en) seen = 1'b1;
      else begin
        access_wait++;
        chk("idle_noack", {bus.p1_ack, bus.p0_ack}, 2'b00);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: got no strobe within 6 cycles, required one");
      return;
    end
    chk("acc_we",    bus.mem_write_en, we);
    chk("acc_re",    bus.mem_read_en, !we);
    chk("acc_addr",  bus.mem_addr, a);
    chk("acc_wdata", bus.mem_wdata, d);
    chk("acc_noack", {bus.p1_ack, bus.p0_ack}, 2'b00);
    if (scramble) drive(win, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    @(posedge clk); #1;
    chk("ack_win", {bus.p1_ack, bus.p0_ack}, (win == 1) ? 2'b10 : 2'b01);
    got_rdata = (win == 1) ? bus.p1_rdata : bus.p0_rdata;
    chk("rdata_win",   got_rdata, exp_rd);
    chk("rdata_other", (win == 1) ? bus.p0_rdata : bus.p1_rdata, 16'h0);
    chk("resp_strobes", {bus.mem_write_en, bus.mem_read_en}, 2'b00);
    chk("resp_addr",   bus.mem_addr, 16'h0);
    if (we) ref_mem[a[7:0]] = d;
    ptr_m        = 1 - win;
    last_win     = win;
    last_ack_cyc = cyc;
    if (!keep) begin
      if (win == 1) bus.p1_req = 1'b0;
      else          bus.p0_req = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
  endtask

  initial begin
    int          prev_cyc;
    bit          p0_served;
    logic [1:0]  mask;
    int          n;

    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);

    vecs[0] = '{port: 1'b0, we: 1'b1, addr: 16'h0003, wdata: 16'hBEEF, exp_rdata: 16'h0000};
    vecs[1] = '{port: 1'b1, we: 1'b0, addr: 16'h0003, wdata: 16'h0000, exp_rdata: 16'hBEEF};
    vecs[2] = '{port: 1'b0, we: 1'b1, addr: 16'h0007, wdata: 16'h00A5, exp_rdata: 16'h0000};
    vecs[3] = '{port: 1'b0, we: 1'b0, addr: 16'h0007, wdata: 16'h0000, exp_rdata: 16'h00A5};
    vecs[4] = '{port: 1'b1, we: 1'b1, addr: 16'hFF00, wdata: 16'hFFFF, exp_rdata: 16'h0000};
    vecs[5] = '{port: 1'b0, we: 1'b0, addr: 16'hFF00, wdata: 16'h0000, exp_rdata: 16'hFFFF};

    // reset state, with a request held to show it is ignored
    bus.p0_req = 1'b1;
    bus.p0_we  = 1'b1;
    repeat (2) @(posedge clk);
    mem_init = 1'b0;
    @(posedge clk); #1;
    chk("rst_acks",    {bus.p1_ack, bus.p0_ack}, 2'b00);
    chk("rst_rdata",   {bus.p1_rdata, bus.p0_rdata}, 32'h0);
    chk("rst_strobes", {bus.mem_write_en, bus.mem_read_en}, 2'b00);
    chk("rst_addr",    bus.mem_addr, 16'h0);
    chk("rst_wdata",   bus.mem_wdata, 16'h0);
    bus.p0_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // directed vector table
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].port, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      serve(1'b0, 1'b0);
      if (i == 0) chk("first_arb_latency", access_wait, 0);
      chk("vec_port",  last_win, vecs[i].port);
      chk("vec_rdata", got_rdata, vecs[i].exp_rdata);
    end

    // both ports requesting continuously from reset: strict alternation
    apply_reset();
    drive(0, 1'b1, 1'b0, 16'h0003, 16'h0);
    drive(1, 1'b1, 1'b0, 16'h0007, 16'h0);
    prev_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      serve(1'b1, 1'b0);
      chk("rr_order", last_win, k % 2);
      if (k > 0) chk("ack_spacing", last_ack_cyc - prev_cyc, 3);
      prev_cyc = last_ack_cyc;
    end
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;

    // p1 hammering, p0 asks once
    drive(1, 1'b1, 1'b0, 16'h0003, 16'h0);
    serve(1'b0, 1'b0);
    bus.p1_req = 1'b1;
    drive(0, 1'b1, 1'b1, 16'h0009, 16'h5A5A);
    p0_served = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (!p0_served) begin
        serve(1'b0, 1'b0);
        if (last_win == 0) p0_served = 1'b1;
        else bus.p1_req = 1'b1;
      end
    end
    chk("no_starve", p0_served, 1'b1);
    bus.p1_req = 1'b0;

    // reset during the ACCESS of a write must abort it
    drive(0, 1'b1, 1'b1, 16'h0005, 16'h1111);
    serve(1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 16'h0005, 16'h1234);
    @(posedge clk); #1;
    chk("abort_strobe_up", bus.mem_write_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_strobe_down", bus.mem_write_en, 1'b0);
    chk("abort_addr", bus.mem_addr, 16'h0);
    bus.p0_req = 1'b0;
    ptr_m = 0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_noack", {bus.p1_ack, bus.p0_ack}, 2'b00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_noack_after", {bus.p1_ack, bus.p0_ack}, 2'b00);
    end
    drive(0, 1'b1, 1'b0, 16'h0005, 16'h0);
    serve(1'b0, 1'b0);
    chk("abort_first_latency", access_wait, 0);
    chk("abort_prior_data", got_rdata, 16'h1111);

    // randomized traffic against the reference model
    for (int r = 0; r < 40; r++) begin
      mask = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        if (mask[p]) begin
          drive(p, 1'b1, 1'($urandom_range(0, 1)),
                {($urandom_range(0, 3) == 0) ? 8'hA0 : 8'h00, 8'($urandom_range(0, 15))},
                16'($urandom));
        end
      end
      n = (mask == 2'b11) ? 2 : 1;
      for (int k = 0; k < n; k++) serve(1'b0, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
